// File: rtl/fpu_pkg.sv
// Shared FPU opcode constants, register-file geometry and opcode decode helpers.
package fpu_pkg;

  localparam logic [5:0] OP_FADD  = 6'b110000;
  localparam logic [5:0] OP_FSUB  = 6'b110001;
  localparam logic [5:0] OP_FMUL  = 6'b110010;
  localparam logic [5:0] OP_FMULN = 6'b110011;
  localparam logic [5:0] OP_FINV  = 6'b110100;
  localparam logic [5:0] OP_FSQRT = 6'b110101;

  localparam int unsigned FPU_LATENCY = 3;
  localparam int unsigned FREG_AW     = 5;

  function automatic logic is_fpu_op(input logic [5:0] op);
    return (op >= OP_FADD) && (op <= OP_FSQRT);
  endfunction

  // finv and fsqrt are unary, so their rt field is ignored for hazards.
  function automatic logic uses_rt(input logic [5:0] op);
    return !((op == OP_FINV) || (op == OP_FSQRT));
  endfunction

endpackage

// File: rtl/fpu_inflight_pipe.sv
// LATENCY-deep {valid, addr} shift register tracking FPU ops in flight; head is the
// entry writing back this cycle.
module fpu_inflight_pipe
  import fpu_pkg::*;
#(
  parameter int unsigned LATENCY = FPU_LATENCY,
  parameter int unsigned AW      = FREG_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push_valid,
  input  logic [AW-1:0] i_push_addr,
  output logic          o_head_valid,
  output logic [AW-1:0] o_head_addr
);

  logic [LATENCY-1:0] r_valid;
  logic [AW-1:0]      r_addr [LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_addr  <= '{default: '0};
    end else begin
      r_valid[0] <= i_push_valid;
      r_addr[0]  <= i_push_addr;
      for (int k = 1; k < LATENCY; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_addr[k]  <= r_addr[k-1];
      end
    end
  end

  assign o_head_valid = r_valid[LATENCY-1];
  assign o_head_addr  = r_addr[LATENCY-1];

endmodule

// File: rtl/fpu_issue_scoreboard.sv
// FPU issue scoreboard: RAW/WAW stall, FP register-file write-port arbitration, load
// starvation guard. Define FPU_SCOREBOARD_STATS_EN to add stall/fire counters.
module fpu_issue_scoreboard
  import fpu_pkg::*;
#(
  parameter int unsigned LATENCY      = FPU_LATENCY,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_issue_valid,
  input  logic [5:0]         i_issue_op,
  input  logic [FREG_AW-1:0] i_issue_rd,
  input  logic [FREG_AW-1:0] i_issue_rs,
  input  logic [FREG_AW-1:0] i_issue_rt,
  output logic               o_stall,
  output logic               o_fire,
  input  logic               i_ld_req,
  input  logic [FREG_AW-1:0] i_ld_addr,
  output logic               o_ld_grant,
  output logic               o_wb_enable,
  output logic [FREG_AW-1:0] o_wb_addr,
  output logic               o_wb_sel
`ifdef FPU_SCOREBOARD_STATS_EN
  ,
  output logic [31:0]        o_stat_stall_cycles,
  output logic [31:0]        o_stat_fire_count
`endif
);

  localparam logic [2:0] StarveLim = 3'(STARVE_LIMIT);

  logic [31:0]        r_pend;
  logic [31:0]        w_pend_d;
  logic [2:0]         r_starve;
  logic [2:0]         w_starve_d;
  logic               w_fpu_op;
  logic               w_hazard;
  logic               w_block_issue;
  logic               w_head_valid;
  logic [FREG_AW-1:0] w_head_addr;

  fpu_inflight_pipe #(
    .LATENCY (LATENCY),
    .AW      (FREG_AW)
  ) u_pipe (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_push_valid (o_fire),
    .i_push_addr  (i_issue_rd),
    .o_head_valid (w_head_valid),
    .o_head_addr  (w_head_addr)
  );

  // Registered pend only: a write completing this cycle still blocks (no bypass).
  assign w_fpu_op      = is_fpu_op(i_issue_op);
  assign w_hazard      = r_pend[i_issue_rs] | (uses_rt(i_issue_op) & r_pend[i_issue_rt]) |
                         r_pend[i_issue_rd];
  assign w_block_issue = (r_starve >= StarveLim) & i_ld_req;
  assign o_stall       = i_issue_valid & w_fpu_op & (w_hazard | w_block_issue);
  assign o_fire        = i_issue_valid & w_fpu_op & ~o_stall;

  // A load waits behind any in-flight write to its register; FPU always owns the port.
  assign o_ld_grant = i_ld_req & ~w_head_valid & ~r_pend[i_ld_addr];

  always_comb begin
    o_wb_enable = 1'b0;
    o_wb_addr   = '0;
    o_wb_sel    = 1'b0;
    if (w_head_valid) begin
      o_wb_enable = 1'b1;
      o_wb_addr   = w_head_addr;
    end else if (o_ld_grant) begin
      o_wb_enable = 1'b1;
      o_wb_addr   = i_ld_addr;
      o_wb_sel    = 1'b1;
    end
  end

  always_comb begin
    w_pend_d = r_pend;
    if (w_head_valid) w_pend_d[w_head_addr] = 1'b0;
    if (o_fire)       w_pend_d[i_issue_rd]  = 1'b1;
  end

  always_comb begin
    w_starve_d = r_starve;
    if (!i_ld_req || o_ld_grant) begin
      w_starve_d = '0;
    end else if (r_starve != 3'd7) begin
      w_starve_d = r_starve + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend   <= '0;
      r_starve <= '0;
    end else begin
      r_pend   <= w_pend_d;
      r_starve <= w_starve_d;
    end
  end

`ifdef FPU_SCOREBOARD_STATS_EN
  logic [31:0] r_stat_stall;
  logic [31:0] r_stat_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_stall <= '0;
      r_stat_fire  <= '0;
    end else begin
      if (o_stall) r_stat_stall <= r_stat_stall + 32'd1;
      if (o_fire)  r_stat_fire  <= r_stat_fire + 32'd1;
    end
  end

  assign o_stat_stall_cycles = r_stat_stall;
  assign o_stat_fire_count   = r_stat_fire;
`endif

endmodule
